data_mem_responder: RTL and testbench

Memory-side responder for the data stage's load/store port. It accepts one right-aligned byte, half or word request at a time over a valid/ready handshake. Stores are steered into the correct byte lanes of an internal word-organised RAM. Loads are returned right-aligned and zero-filled, so the core's load extender applies sign or zero extension. Misaligned, out-of-range and reserved-size accesses complete with an error response and no side effect.

---
 rtl/data_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Load/store responder for the data stage: one byte/half/word request at a time,
// lane-steered into a word-organised RAM, right-aligned zero-filled load data.
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam int         DEPTH    = 2 ** ADDR_W;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic              r_illegal;
    logic [ADDR_W+1:0] r_addr;
    logic [1:0]        r_size;
    logic [31:0]       r_wdata;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [31:0]       r_rsp_rdata;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_illegal;
    logic              w_access_done;
    logic              w_rsp_hs;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_index;
    logic [1:0]        w_lane;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_lanes;
    logic [31:0]       w_word;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load_data;

    assign w_accept      = i_req_valid & r_req_ready;
    assign w_access_done = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign w_rsp_hs      = (r_state == S_RESP) && r_rsp_valid && i_rsp_ready;
    assign w_mem_we      = w_access_done & r_we & ~r_illegal;
    assign w_index       = r_addr[ADDR_W+1:2];
    assign w_lane        = r_addr[1:0];
    assign w_word        = r_mem[w_index];
    assign w_shifted     = w_word >> {w_lane, 3'b000};

    always_comb begin
        w_illegal = 1'b0;
        case (i_req_size)
            2'b00:   w_illegal = 1'b0;
            2'b01:   w_illegal = i_req_addr[0];
            2'b10:   w_illegal = |i_req_addr[1:0];
            default: w_illegal = 1'b1;
        endcase
        if ((i_req_addr >> (ADDR_W + 2)) != 32'd0) w_illegal = 1'b1;
    end

    always_comb begin
        w_be          = 4'b0000;
        w_wdata_lanes = r_wdata;
        w_load_data   = w_word;
        case (r_size)
            2'b00: begin
                w_be          = 4'b0001 << w_lane;
                w_wdata_lanes = {4{r_wdata[7:0]}};
                w_load_data   = {24'd0, w_shifted[7:0]};
            end
            2'b01: begin
                w_be          = 4'b0011 << w_lane;
                w_wdata_lanes = {2{r_wdata[15:0]}};
                w_load_data   = {16'd0, w_shifted[15:0]};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next_state = S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0) w_next_state = S_RESP;
            S_RESP:   if (w_rsp_hs) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Illegal requests pass through ACCESS with a zero count so that the error
    // response appears one edge after accept, with the RAM write suppressed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_illegal   <= 1'b0;
            r_addr      <= '0;
            r_size      <= 2'b00;
            r_wdata     <= 32'd0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_state     <= w_next_state;
            r_req_ready <= (w_next_state == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we      <= i_req_we;
                        r_addr    <= i_req_addr[ADDR_W+1:0];
                        r_size    <= i_req_size;
                        r_wdata   <= i_req_wdata;
                        r_illegal <= w_illegal;
                        r_cnt     <= w_illegal ? 4'd0 : CNT_INIT;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= r_illegal;
                        r_rsp_rdata <= (r_illegal || r_we) ? 32'd0 : w_load_data;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM has no reset; only enabled byte lanes are written.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_index][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
            end
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-array model predicts each
// response when the request is accepted; responses are popped and compared.
module tb_data_mem_responder;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 3;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int PERIOD  = 10;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWe;
    logic [31:0] reqAddr;
    logic [1:0]  reqSize;
    logic [31:0] reqWdata;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdata;
    logic        rspErr;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] modelBytes [4*DEPTH];
    int         checkCount = 0;
    int         errorCount = 0;
    time        acceptTime = 0;

    always #(PERIOD/2) clk = ~clk;

    data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_req_valid(reqValid),
        .o_req_ready(reqReady),
        .i_req_we   (reqWe),
        .i_req_addr (reqAddr),
        .i_req_size (reqSize),
        .i_req_wdata(reqWdata),
        .o_rsp_valid(rspValid),
        .i_rsp_ready(rspReady),
        .o_rsp_rdata(rspRdata),
        .o_rsp_err  (rspErr)
    );

    // Byte-granular reference: legality by size alignment and byte range.
    function automatic exp_t model_apply(bit we, logic [31:0] addr, logic [1:0] size,
                                         logic [31:0] wd);
        exp_t e;
        int   nb;
        nb      = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        e.rdata = 32'd0;
        e.err   = 1'b0;
        e.lat   = LATENCY;
        if (size == 2'b11 || (addr % nb) != 0 || addr >= 32'(4*DEPTH)) begin
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            for (int i = 0; i < nb; i++) begin
                if (we) modelBytes[int'(addr) + i] = wd[8*i +: 8];
                else    e.rdata[8*i +: 8] = modelBytes[int'(addr) + i];
            end
        end
        return e;
    endfunction

    task automatic send_req(input bit we, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wd, input bit track);
        int budget = 0;
        @(negedge clk);
        reqValid = 1'b1;
        reqWe    = we;
        reqAddr  = addr;
        reqSize  = size;
        reqWdata = wd;
        while (!reqReady) begin
            @(negedge clk);
            budget++;
            if (budget > 100) begin
                errorCount++;
                $display("[TB] FAIL req_ready_timeout got 0 want 1");
                $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
                $fatal(1, "[TB] request never accepted");
            end
        end
        @(posedge clk);
        acceptTime = $time;
        #1;
        reqValid = 1'b0;
        reqWe    = 1'($urandom);
        reqAddr  = $urandom;
        reqSize  = 2'($urandom);
        reqWdata = $urandom;
        if (track) sb.push_back(model_apply(we, addr, size, wd));
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic er, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rspValid && lat < 50);
        rd = rspRdata;
        er = rspErr;
    endtask

    task automatic finish_rsp();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqSize = '0;
        reqWdata = '0; rspReady = 1'b1;
        #1;
        checkCount += 4;
        if (reqReady !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_req_ready got %b want 0", reqReady); end
        if (rspValid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rspValid); end
        if (rspRdata !== 32'd0) begin errorCount++; $display("[TB] FAIL reset_rdata got %h want 0", rspRdata); end
        if (rspErr !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_err got %b want 0", rspErr); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkCount++;
        if (reqReady !== 1'b0) begin errorCount++; $display("[TB] FAIL ready_before_edge got %b want 0", reqReady); end
        @(posedge clk);
        #1;
        checkCount++;
        if (reqReady !== 1'b1) begin errorCount++; $display("[TB] FAIL ready_after_edge got %b want 1", reqReady); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat; exp_t e;
        for (int i = 0; i < 2; i++) begin
            send_req(i == 0, 32'h10, 2'b10, 32'hDEADBEEF, 1'b1);
            checkCount++;
            if (reqReady !== 1'b0) begin errorCount++; $display("[TB] FAIL busy_ready got %b want 0", reqReady); end
            wait_rsp(rd, er, lat);
            e = sb.pop_front();
            checkCount += 3;
            if (lat !== e.lat) begin errorCount++; $display("[TB] FAIL sl_latency got %0d want %0d", lat, e.lat); end
            if (rd !== e.rdata) begin errorCount++; $display("[TB] FAIL sl_rdata got %h want %h", rd, e.rdata); end
            if (er !== e.err) begin errorCount++; $display("[TB] FAIL sl_err got %b want %b", er, e.err); end
            finish_rsp();
            checkCount += 2;
            if (rspValid !== 1'b0) begin errorCount++; $display("[TB] FAIL sl_valid_clear got %b want 0", rspValid); end
            if (reqReady !== 1'b1) begin errorCount++; $display("[TB] FAIL sl_ready_back got %b want 1", reqReady); end
        end
    endtask

    task automatic test_lanes();
        logic [31:0] rd; logic er; int lat; exp_t e;
        bit          weT [6];
        logic [31:0] adT [6];
        logic [1:0]  szT [6];
        logic [31:0] wdT [6];
        weT = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        adT = '{32'h13, 32'h10, 32'h10, 32'h13, 32'h12, 32'h11};
        szT = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00};
        wdT = '{32'hFFFFFF5A, 32'hABCD1234, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            send_req(weT[i], adT[i], szT[i], wdT[i], 1'b1);
            wait_rsp(rd, er, lat);
            e = sb.pop_front();
            checkCount += 3;
            if (lat !== e.lat) begin errorCount++; $display("[TB] FAIL lane_latency[%0d] got %0d want %0d", i, lat, e.lat); end
            if (rd !== e.rdata) begin errorCount++; $display("[TB] FAIL lane_rdata[%0d] got %h want %h", i, rd, e.rdata); end
            if (er !== e.err) begin errorCount++; $display("[TB] FAIL lane_err[%0d] got %b want %b", i, er, e.err); end
            finish_rsp();
        end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic er; int lat; exp_t e;
        bit          weT [5];
        logic [31:0] adT [5];
        logic [1:0]  szT [5];
        logic [31:0] wdT [5];
        weT = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        adT = '{32'h11, 32'h12, 32'h10, 32'h10, 32'h10};
        szT = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b10};
        wdT = '{32'h0000FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            send_req(weT[i], adT[i], szT[i], wdT[i], 1'b1);
            wait_rsp(rd, er, lat);
            e = sb.pop_front();
            checkCount += 3;
            if (lat !== e.lat) begin errorCount++; $display("[TB] FAIL ill_latency[%0d] got %0d want %0d", i, lat, e.lat); end
            if (rd !== e.rdata) begin errorCount++; $display("[TB] FAIL ill_rdata[%0d] got %h want %h", i, rd, e.rdata); end
            if (er !== e.err) begin errorCount++; $display("[TB] FAIL ill_err[%0d] got %b want %b", i, er, e.err); end
            finish_rsp();
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat; exp_t e;
        bit          weT [5];
        logic [31:0] adT [5];
        logic [1:0]  szT [5];
        logic [31:0] wdT [5];
        weT = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        adT = '{32'h0, 32'(4*DEPTH), 32'h00400000, 32'(4*DEPTH), 32'h0};
        szT = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10};
        wdT = '{32'h01020304, 32'hCAFEF00D, 32'h000000EE, 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            send_req(weT[i], adT[i], szT[i], wdT[i], 1'b1);
            wait_rsp(rd, er, lat);
            e = sb.pop_front();
            checkCount += 3;
            if (lat !== e.lat) begin errorCount++; $display("[TB] FAIL oor_latency[%0d] got %0d want %0d", i, lat, e.lat); end
            if (rd !== e.rdata) begin errorCount++; $display("[TB] FAIL oor_rdata[%0d] got %h want %h", i, rd, e.rdata); end
            if (er !== e.err) begin errorCount++; $display("[TB] FAIL oor_err[%0d] got %b want %b", i, er, e.err); end
            finish_rsp();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; exp_t e;
        rspReady = 1'b0;
        send_req(1'b0, 32'h13, 2'b00, 32'h0, 1'b1);
        wait_rsp(rd, er, lat);
        e = sb.pop_front();
        checkCount += 2;
        if (rd !== e.rdata) begin errorCount++; $display("[TB] FAIL bp_rdata got %h want %h", rd, e.rdata); end
        if (er !== e.err) begin errorCount++; $display("[TB] FAIL bp_err got %b want %b", er, e.err); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkCount += 4;
            if (rspValid !== 1'b1) begin errorCount++; $display("[TB] FAIL bp_hold_valid[%0d] got %b want 1", k, rspValid); end
            if (rspRdata !== e.rdata) begin errorCount++; $display("[TB] FAIL bp_hold_rdata[%0d] got %h want %h", k, rspRdata, e.rdata); end
            if (rspErr !== e.err) begin errorCount++; $display("[TB] FAIL bp_hold_err[%0d] got %b want %b", k, rspErr, e.err); end
            if (reqReady !== 1'b0) begin errorCount++; $display("[TB] FAIL bp_hold_ready[%0d] got %b want 0", k, reqReady); end
        end
        @(negedge clk);
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        checkCount += 2;
        if (rspValid !== 1'b0) begin errorCount++; $display("[TB] FAIL bp_release_valid got %b want 0", rspValid); end
        if (reqReady !== 1'b1) begin errorCount++; $display("[TB] FAIL bp_release_ready got %b want 1", reqReady); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; exp_t e; time prevAccept;
        logic [31:0] adT [4];
        logic [1:0]  szT [4];
        adT = '{32'h10, 32'h12, 32'h13, 32'h0};
        szT = '{2'b10, 2'b01, 2'b00, 2'b10};
        prevAccept = 0;
        for (int i = 0; i < 4; i++) begin
            send_req(1'b0, adT[i], szT[i], 32'h0, 1'b1);
            if (i > 0) begin
                checkCount++;
                if ((acceptTime - prevAccept) !== time'(PERIOD*(LATENCY+2))) begin
                    errorCount++;
                    $display("[TB] FAIL b2b_interval[%0d] got %0d want %0d", i, acceptTime - prevAccept, PERIOD*(LATENCY+2));
                end
            end
            prevAccept = acceptTime;
            wait_rsp(rd, er, lat);
            e = sb.pop_front();
            checkCount += 2;
            if (rd !== e.rdata) begin errorCount++; $display("[TB] FAIL b2b_rdata[%0d] got %h want %h", i, rd, e.rdata); end
            if (er !== e.err) begin errorCount++; $display("[TB] FAIL b2b_err[%0d] got %b want %b", i, er, e.err); end
            finish_rsp();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; exp_t e;
        send_req(1'b1, 32'h20, 2'b10, 32'h11223344, 1'b1);
        wait_rsp(rd, er, lat);
        e = sb.pop_front();
        finish_rsp();
        send_req(1'b0, 32'h20, 2'b10, 32'h0, 1'b1);
        wait_rsp(rd, er, lat);
        e = sb.pop_front();
        checkCount++;
        if (rd !== e.rdata) begin errorCount++; $display("[TB] FAIL rm_known got %h want %h", rd, e.rdata); end
        finish_rsp();
        send_req(1'b1, 32'h20, 2'b10, 32'hFFFFFFFF, 1'b0);
        @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkCount += 4;
        if (reqReady !== 1'b0) begin errorCount++; $display("[TB] FAIL rm_req_ready got %b want 0", reqReady); end
        if (rspValid !== 1'b0) begin errorCount++; $display("[TB] FAIL rm_rsp_valid got %b want 0", rspValid); end
        if (rspRdata !== 32'd0) begin errorCount++; $display("[TB] FAIL rm_rdata got %h want 0", rspRdata); end
        if (rspErr !== 1'b0) begin errorCount++; $display("[TB] FAIL rm_err got %b want 0", rspErr); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        send_req(1'b0, 32'h20, 2'b10, 32'h0, 1'b1);
        wait_rsp(rd, er, lat);
        e = sb.pop_front();
        checkCount += 2;
        if (rd !== e.rdata) begin errorCount++; $display("[TB] FAIL rm_old_word got %h want %h", rd, e.rdata); end
        if (er !== e.err) begin errorCount++; $display("[TB] FAIL rm_old_err got %b want %b", er, e.err); end
        finish_rsp();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_lanes();
        test_illegal();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    initial begin
        #(PERIOD * 20000);
        errorCount++;
        $display("[TB] FAIL watchdog got timeout want completion");
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
